// File: rtl/audio_tone_mixer.sv
// Pops one stereo pair from the capture side, adds a switch-selected square tone
// with signed saturation, and pushes the result to the playback side.
module audio_tone_mixer #(
  parameter int                       DATA_W    = 32,
  parameter logic signed [DATA_W-1:0] AMPLITUDE = 32'h0FFFFFF0,
  parameter logic [10:0]              BASE_LSB  = 11'h3B8
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [7:0]               sw,
  input  logic                     clear_sat,
  input  logic                     audio_in_available,
  input  logic signed [DATA_W-1:0] left_in,
  input  logic signed [DATA_W-1:0] right_in,
  input  logic                     audio_out_allowed,
  output logic                     read_audio_in,
  output logic                     write_audio_out,
  output logic signed [DATA_W-1:0] left_out,
  output logic signed [DATA_W-1:0] right_out,
  output logic                     tone_active,
  output logic                     sat_flag
);

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MIX, S_WRITE} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [18:0]                r_count;
  logic [18:0]                r_period;
  logic                       r_phase;
  logic                       r_tone_active;
  logic signed [DATA_W-1:0]   r_lat_l;
  logic signed [DATA_W-1:0]   r_lat_r;
  logic signed [DATA_W-1:0]   r_left_out;
  logic signed [DATA_W-1:0]   r_right_out;
  logic                       r_sat;
  logic signed [DATA_W-1:0]   w_tone;
  logic                       w_read;
  logic                       w_write;
  logic                       w_clip;

  function automatic logic signed [DATA_W-1:0] sat_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? SAT_MIN : SAT_MAX;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic add_clips(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    return s[DATA_W] ^ s[DATA_W-1];
  endfunction

  // Free-running tone: sw is only sampled at a half-period boundary, so changes never glitch
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_count       <= '0;
      r_period      <= '0;
      r_phase       <= 1'b1;
      r_tone_active <= 1'b0;
    end else if (r_count == r_period) begin
      r_count       <= '0;
      r_period      <= {sw, BASE_LSB};
      r_phase       <= ~r_phase;
      r_tone_active <= (sw != 8'd0);
    end else begin
      r_count <= r_count + 19'd1;
    end
  end

  assign w_tone = r_tone_active ? (r_phase ? AMPLITUDE : -AMPLITUDE) : '0;
  assign w_clip = add_clips(r_lat_l, w_tone) | add_clips(r_lat_r, w_tone);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (audio_in_available && audio_out_allowed) w_next = S_MIX;
      S_MIX:   w_next = S_WRITE;
      S_WRITE: if (audio_out_allowed) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are combinational so the pop/push lands in the same cycle the FSM commits
  always_comb begin
    w_read  = 1'b0;
    w_write = 1'b0;
    if (!reset) begin
      w_read  = (r_state == S_IDLE) && audio_in_available && audio_out_allowed;
      w_write = (r_state == S_WRITE) && audio_out_allowed;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_read) begin
      r_lat_l <= left_in;
      r_lat_r <= right_in;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_left_out  <= '0;
      r_right_out <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (r_state == S_MIX) begin
        r_left_out  <= sat_add(r_lat_l, w_tone);
        r_right_out <= sat_add(r_lat_r, w_tone);
      end
      if (r_state == S_MIX && w_clip) r_sat <= 1'b1;
      else if (clear_sat)             r_sat <= 1'b0;
    end
  end

  assign read_audio_in   = w_read;
  assign write_audio_out = w_write;
  assign left_out        = r_left_out;
  assign right_out       = r_right_out;
  assign tone_active     = r_tone_active;
  assign sat_flag        = r_sat;

endmodule

// File: tb/tb_audio_tone_mixer.sv
// Bench for audio_tone_mixer: cycle model of the handshake and tone, checked on every
// falling edge, plus directed literal expectations.
module tb_audio_tone_mixer;

  localparam longint AMP  = 64'h0FFFFFF0;
  localparam longint PMAX = 64'h7FFFFFFF;
  localparam longint PMIN = -64'h80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw = 8'd0;
  logic        clear_sat = 1'b0;
  logic        avail = 1'b0;
  logic        allowed = 1'b0;
  logic signed [31:0] left_in = '0;
  logic signed [31:0] right_in = '0;
  logic        rd, wr, tact, sat;
  logic signed [31:0] lout, rout;

  int total = 0;
  int bad = 0;
  int write_cnt = 0;

  audio_tone_mixer dut (
    .CLOCK_50(clk), .reset(rst), .sw(sw), .clear_sat(clear_sat),
    .audio_in_available(avail), .left_in(left_in), .right_in(right_in),
    .audio_out_allowed(allowed), .read_audio_in(rd), .write_audio_out(wr),
    .left_out(lout), .right_out(rout), .tone_active(tact), .sat_flag(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: stage 0 = waiting for a pair, 1 = pair held, 2 = result waiting for space
  int          m_stage = 0;
  bit          m_pos = 1'b1;
  bit          m_active = 1'b0;
  int          m_left = 1;
  longint      m_in_l = 0, m_in_r = 0;
  logic [31:0] m_out_l = '0, m_out_r = '0;
  bit          m_sat = 1'b0;

  function automatic logic [31:0] clip(input longint s, inout bit hit);
    if (s > PMAX) begin hit = 1'b1; return 32'h7FFFFFFF; end
    if (s < PMIN) begin hit = 1'b1; return 32'h80000000; end
    return s[31:0];
  endfunction

  always @(posedge clk) begin
    longint tone;
    bit hit;
    if (rst) begin
      m_stage = 0; m_pos = 1'b1; m_active = 1'b0; m_left = 1;
      m_out_l = '0; m_out_r = '0; m_sat = 1'b0;
    end else begin
      tone = m_active ? (m_pos ? AMP : -AMP) : 0;
      hit = 1'b0;
      case (m_stage)
        0: if (avail && allowed) begin
             m_in_l = longint'(left_in); m_in_r = longint'(right_in); m_stage = 1;
           end
        1: begin
             m_out_l = clip(m_in_l + tone, hit);
             m_out_r = clip(m_in_r + tone, hit);
             m_stage = 2;
           end
        default: if (allowed) m_stage = 0;
      endcase
      if (hit) m_sat = 1'b1;
      else if (clear_sat) m_sat = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_pos = !m_pos;
        m_active = (sw != 8'd0);
        m_left = int'({sw, 11'h3B8}) + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (wr) write_cnt++;
    if (rst) begin
      chk("rst_read", 32'(rd), 32'd0);
      chk("rst_write", 32'(wr), 32'd0);
      chk("rst_left", lout, 32'd0);
      chk("rst_tone", 32'(tact), 32'd0);
    end else begin
      chk("read", 32'(rd), 32'(m_stage == 0 && avail && allowed));
      chk("write", 32'(wr), 32'(m_stage == 2 && allowed));
      chk("left_out", lout, m_out_l);
      chk("right_out", rout, m_out_r);
      chk("tone_active", 32'(tact), 32'(m_active));
      chk("sat_flag", 32'(sat), 32'(m_sat));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_pair(input logic [31:0] l, input logic [31:0] r);
    left_in = l; right_in = r; avail = 1'b1; allowed = 1'b1;
    tick();
    avail = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int w0;
    #1;
    chk("reset_read", 32'(rd), 32'd0);
    chk("reset_sat", 32'(sat), 32'd0);
    chk("reset_left", lout, 32'd0);
    repeat (3) tick();
    rst = 1'b0;

    // Muted tone: sample passes through unchanged
    do_pair(32'h00001000, 32'hFFFFFFFF);
    chk("t1_left", lout, 32'h00001000);
    chk("t1_right", rout, 32'hFFFFFFFF);
    chk("t1_tone", 32'(tact), 32'd0);

    // sw=1: first boundary at cycle 0 flips to the negative half
    rst = 1'b1; sw = 8'h01;
    repeat (2) tick();
    rst = 1'b0;
    do_pair(32'h0, 32'h0);
    chk("t2_neg", lout, 32'hF0000010);
    chk("t2_active", 32'(tact), 32'd1);
    repeat ('hBB9) tick();
    do_pair(32'h0, 32'h0);
    chk("t2_pos", lout, 32'h0FFFFFF0);

    do_pair(32'h7FFFFFF0, 32'h0);
    chk("t3_clip_hi", lout, 32'h7FFFFFFF);
    chk("t3_sat", 32'(sat), 32'd1);
    clear_sat = 1'b1;
    tick();
    clear_sat = 1'b0;
    chk("t3_clear", 32'(sat), 32'd0);

    repeat ('hBB9) tick();
    do_pair(32'h0, 32'h80000010);
    chk("t4_clip_lo", rout, 32'h80000000);
    chk("t4_sat", 32'(sat), 32'd1);

    // Playback blocked in WRITE for 10 cycles
    w0 = write_cnt;
    left_in = 32'd5; avail = 1'b1; allowed = 1'b1;
    tick();
    avail = 1'b0; allowed = 1'b0;
    tick();
    repeat (10) tick();
    chk("t5_nowrite", 32'(write_cnt - w0), 32'd0);
    allowed = 1'b1;
    tick();
    tick();
    chk("t5_one_write", 32'(write_cnt - w0), 32'd1);
    chk("t5_left", lout, 32'hF0000015);

    // Back-to-back streaming across boundaries, sw changed mid half-period
    left_in = 32'h12345678; right_in = -32'sd5; avail = 1'b1; allowed = 1'b1;
    repeat (1000) tick();
    sw = 8'h02;
    repeat (9000) tick();
    avail = 1'b0;
    repeat (4) tick();

    // Reset while a pair is in MIX
    left_in = 32'd7; avail = 1'b1; allowed = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("t7_read", 32'(rd), 32'd0);
    chk("t7_write", 32'(wr), 32'd0);
    chk("t7_left", lout, 32'd0);
    avail = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    do_pair(32'h100, 32'h200);
    chk("t7_after_left", lout, 32'hF0000110);
    chk("t7_after_right", rout, 32'hF0000210);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
